// File: rtl/cache_fill_ctrl.sv
// Cache-line fill controller: optional dirty-victim write-back, then a
// pipelined line read in which requests are issued back-to-back while
// in-order responses are written into the data array. The tag is written
// once the last word has landed.
module cache_fill_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WORDS    = 8,
  parameter int BYTE_OFF = 1,
  localparam int IDX_W   = $clog2(WORDS),
  localparam int OFF_W   = IDX_W + BYTE_OFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_address,
  input  logic [DATA_W-1:0] victim_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [IDX_W-1:0]  word_index,
  output logic              memory_enable,
  output logic              memory_wr,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_wdata
);

  localparam int BASE_W = ADDR_W - OFF_W;

  // Issue/receive counters carry one extra bit so "all WORDS issued" is
  // representable without wrapping back to word 0.
  localparam logic [IDX_W:0]   CNT_WORDS = (IDX_W + 1)'(WORDS);
  localparam logic [IDX_W:0]   RX_LAST   = (IDX_W + 1)'(WORDS - 1);
  localparam logic [IDX_W-1:0] WB_LAST   = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    TAG  = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [BASE_W-1:0]   miss_base_reg, miss_base_next;
  logic [BASE_W-1:0]   victim_base_reg, victim_base_next;
  logic [IDX_W-1:0]    wb_cnt_reg, wb_cnt_next;
  logic [IDX_W:0]      iss_cnt_reg, iss_cnt_next;
  logic [IDX_W:0]      rx_cnt_reg, rx_cnt_next;

  // Offset bits of the incoming addresses are irrelevant: only line bases
  // are kept.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{miss_address[OFF_W-1:0], victim_address[OFF_W-1:0]};

  // State and counter registers; reset returns everything to IDLE/zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      miss_base_reg   <= '0;
      victim_base_reg <= '0;
      wb_cnt_reg      <= '0;
      iss_cnt_reg     <= '0;
      rx_cnt_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      miss_base_reg   <= miss_base_next;
      victim_base_reg <= victim_base_next;
      wb_cnt_reg      <= wb_cnt_next;
      iss_cnt_reg     <= iss_cnt_next;
      rx_cnt_reg      <= rx_cnt_next;
    end
  end

  // Next-state, counter updates and all outputs, decoded from current state.
  always_comb begin
    state_next       = state_reg;
    miss_base_next   = miss_base_reg;
    victim_base_next = victim_base_reg;
    wb_cnt_next      = wb_cnt_reg;
    iss_cnt_next     = iss_cnt_reg;
    rx_cnt_next      = rx_cnt_reg;

    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    word_index       = '0;
    memory_enable    = 1'b0;
    memory_wr        = 1'b0;
    memory_address   = '0;
    memory_wdata     = '0;

    case (state_reg)
      IDLE: begin
        if (miss_detected) begin
          miss_base_next   = miss_address[ADDR_W-1:OFF_W];
          victim_base_next = victim_address[ADDR_W-1:OFF_W];
          wb_cnt_next      = '0;
          iss_cnt_next     = '0;
          rx_cnt_next      = '0;
          state_next       = victim_dirty ? WB : FILL;
        end
      end

      WB: begin
        fsm_busy       = 1'b1;
        memory_enable  = 1'b1;
        memory_wr      = 1'b1;
        memory_address = ADDR_W'({victim_base_reg, wb_cnt_reg}) << BYTE_OFF;
        word_index     = wb_cnt_reg;
        memory_wdata   = victim_data;
        if (wb_cnt_reg == WB_LAST) begin
          wb_cnt_next  = '0;
          iss_cnt_next = '0;
          rx_cnt_next  = '0;
          state_next   = FILL;
        end else begin
          wb_cnt_next  = wb_cnt_reg + 1'b1;
        end
      end

      FILL: begin
        fsm_busy   = 1'b1;
        word_index = rx_cnt_reg[IDX_W-1:0];
        // Requests stream out without waiting for responses.
        if (iss_cnt_reg < CNT_WORDS) begin
          memory_enable  = 1'b1;
          memory_address = ADDR_W'({miss_base_reg, iss_cnt_reg[IDX_W-1:0]}) << BYTE_OFF;
          iss_cnt_next   = iss_cnt_reg + 1'b1;
        end
        // In-order responses land at the receive pointer.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          rx_cnt_next      = rx_cnt_reg + 1'b1;
          if (rx_cnt_reg == RX_LAST) begin
            state_next = TAG;
          end
        end
      end

      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: per-cycle vector tables for the
// default configuration plus a short sequence for a 4-word/32-bit variant.
module tb_cache_fill_ctrl;

  typedef struct {
    logic        rst;
    logic        md;
    logic        vd;
    logic        mdv;
    logic [15:0] maddr;
    logic [15:0] vaddr;
    logic        busy;
    logic        wda;
    logic        wta;
    logic [2:0]  idx;
    logic        men;
    logic        mwr;
    logic [15:0] mem_addr;
    logic [15:0] wdata;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        victim_dirty;
  logic [15:0] victim_address;
  logic [15:0] victim_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  word_index;
  logic        memory_enable;
  logic        memory_wr;
  logic [15:0] memory_address;
  logic [15:0] memory_wdata;

  logic        md4;
  logic [15:0] maddr4;
  logic        mdv4;
  logic        busy4;
  logic        wda4;
  logic        wta4;
  logic [1:0]  idx4;
  logic        men4;
  logic        mwr4;
  logic [15:0] addr4;
  logic [31:0] wdata4;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vq[$];

  // Data-array model: each word reads back as D000 + its index.
  assign victim_data = 16'hD000 | {13'b0, word_index};

  cache_fill_ctrl u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .victim_dirty      (victim_dirty),
    .victim_address    (victim_address),
    .victim_data       (victim_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .word_index        (word_index),
    .memory_enable     (memory_enable),
    .memory_wr         (memory_wr),
    .memory_address    (memory_address),
    .memory_wdata      (memory_wdata)
  );

  cache_fill_ctrl #(
    .ADDR_W(16), .DATA_W(32), .WORDS(4), .BYTE_OFF(2)
  ) u_dut4 (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (md4),
    .miss_address      (maddr4),
    .victim_dirty      (1'b0),
    .victim_address    (16'h0000),
    .victim_data       (32'hCAFE_F00D),
    .memory_data_valid (mdv4),
    .fsm_busy          (busy4),
    .write_data_array  (wda4),
    .write_tag_array   (wta4),
    .word_index        (idx4),
    .memory_enable     (men4),
    .memory_wr         (mwr4),
    .memory_address    (addr4),
    .memory_wdata      (wdata4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %h want %h", name, c, act, exp);
    end
  endtask

  function automatic vec_t vz();
    vec_t v;
    v.rst = 1'b1; v.md = 1'b0; v.vd = 1'b0; v.mdv = 1'b0;
    v.maddr = '0; v.vaddr = '0;
    v.busy = 1'b0; v.wda = 1'b0; v.wta = 1'b0; v.idx = '0;
    v.men = 1'b0; v.mwr = 1'b0; v.mem_addr = '0; v.wdata = '0;
    return v;
  endfunction

  // Apply each vector for one cycle and check outputs at the falling edge.
  task automatic run_table(input string name);
    foreach (vq[i]) begin
      @(posedge clk); #1;
      rst_n             = vq[i].rst;
      miss_detected     = vq[i].md;
      victim_dirty      = vq[i].vd;
      memory_data_valid = vq[i].mdv;
      miss_address      = vq[i].maddr;
      victim_address    = vq[i].vaddr;
      @(negedge clk);
      $display("%s c%0d busy=%0d wda=%0d wta=%0d idx=%0d men=%0d wr=%0d addr=%h wd=%h",
               name, i, fsm_busy, write_data_array, write_tag_array, word_index,
               memory_enable, memory_wr, memory_address, memory_wdata);
      chk({name, ".busy"},  i, 32'(fsm_busy),         32'(vq[i].busy));
      chk({name, ".wda"},   i, 32'(write_data_array), 32'(vq[i].wda));
      chk({name, ".wta"},   i, 32'(write_tag_array),  32'(vq[i].wta));
      chk({name, ".idx"},   i, 32'(word_index),       32'(vq[i].idx));
      chk({name, ".men"},   i, 32'(memory_enable),    32'(vq[i].men));
      chk({name, ".wr"},    i, 32'(memory_wr),        32'(vq[i].mwr));
      chk({name, ".addr"},  i, 32'(memory_address),   32'(vq[i].mem_addr));
      chk({name, ".wdata"}, i, 32'(memory_wdata),     32'(vq[i].wdata));
    end
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; miss_detected = 1'b0; victim_dirty = 1'b0;
    memory_data_valid = 1'b0; miss_address = '0; victim_address = '0;
    md4 = 1'b0; maddr4 = '0; mdv4 = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state: one cycle after reset, with valid asserted (ignored in IDLE).
    vq.delete();
    v = vz(); v.mdv = 1'b1; vq.push_back(v);
    run_table("reset");

    // Clean miss at 0x1234, latency 4, no gaps.
    vq.delete();
    for (int c = 0; c <= 14; c++) begin
      v = vz();
      if (c == 0) begin v.md = 1'b1; v.maddr = 16'h1234; end
      if (c >= 1 && c <= 13) v.busy = 1'b1;
      if (c >= 1 && c <= 8) begin v.men = 1'b1; v.mem_addr = 16'h1230 + 16'(2 * (c - 1)); end
      if (c >= 5 && c <= 12) begin v.mdv = 1'b1; v.wda = 1'b1; v.idx = 3'(c - 5); end
      if (c == 13) v.wta = 1'b1;
      vq.push_back(v);
    end
    run_table("clean");

    // Dirty miss: write back 0xABC0..0xABCE, then fill from 0x1230.
    vq.delete();
    for (int c = 0; c <= 22; c++) begin
      v = vz();
      if (c == 0) begin v.md = 1'b1; v.vd = 1'b1; v.maddr = 16'h1234; v.vaddr = 16'hABC6; end
      if (c >= 1 && c <= 21) v.busy = 1'b1;
      if (c >= 1 && c <= 8) begin
        v.men = 1'b1; v.mwr = 1'b1;
        v.mem_addr = 16'hABC0 + 16'(2 * (c - 1));
        v.idx = 3'(c - 1);
        v.wdata = 16'hD000 + 16'(c - 1);
      end
      if (c >= 9 && c <= 16) begin v.men = 1'b1; v.mem_addr = 16'h1230 + 16'(2 * (c - 9)); end
      if (c >= 13 && c <= 20) begin v.mdv = 1'b1; v.wda = 1'b1; v.idx = 3'(c - 13); end
      if (c == 21) v.wta = 1'b1;
      vq.push_back(v);
    end
    run_table("dirty");

    // Gapped responses, a miss pulse during FILL, and a stray valid in IDLE.
    vq.delete();
    for (int c = 0; c <= 22; c++) begin
      v = vz();
      if (c == 0) begin v.md = 1'b1; v.maddr = 16'h1234; end
      if (c == 3) begin v.md = 1'b1; v.vd = 1'b1; v.maddr = 16'h5550; v.vaddr = 16'h7770; end
      if (c >= 1 && c <= 20) v.busy = 1'b1;
      if (c >= 1 && c <= 8) begin v.men = 1'b1; v.mem_addr = 16'h1230 + 16'(2 * (c - 1)); end
      if (c >= 5 && c <= 19) begin
        v.idx = 3'((c - 4) / 2);
        if (((c - 5) % 2) == 0) begin v.mdv = 1'b1; v.wda = 1'b1; end
      end
      if (c == 20) v.wta = 1'b1;
      if (c == 21) v.mdv = 1'b1;
      vq.push_back(v);
    end
    run_table("gap");

    // Reset in cycle 6 of a fill, then a fresh miss that restarts at word 0.
    vq.delete();
    for (int c = 0; c <= 11; c++) begin
      v = vz();
      if (c == 0) begin v.md = 1'b1; v.maddr = 16'h1234; end
      if (c >= 1 && c <= 6) begin v.busy = 1'b1; v.men = 1'b1; v.mem_addr = 16'h1230 + 16'(2 * (c - 1)); end
      if (c >= 5 && c <= 6) begin v.mdv = 1'b1; v.wda = 1'b1; v.idx = 3'(c - 5); end
      if (c == 6) v.rst = 1'b0;
      if (c == 7) v.mdv = 1'b1;
      if (c == 8) begin v.md = 1'b1; v.maddr = 16'h2468; end
      if (c >= 9 && c <= 10) begin v.busy = 1'b1; v.men = 1'b1; v.mem_addr = 16'h2460 + 16'(2 * (c - 9)); end
      if (c == 10) v.rst = 1'b0;
      vq.push_back(v);
    end
    run_table("rst");

    // Variant: 4 words of 32 bits, miss at 0x0F3C, latency 1.
    for (int c = 0; c <= 7; c++) begin
      @(posedge clk); #1;
      md4    = (c == 0);
      maddr4 = 16'h0F3C;
      mdv4   = (c >= 2 && c <= 5);
      @(negedge clk);
      $display("w4 c%0d busy=%0d wda=%0d wta=%0d idx=%0d men=%0d addr=%h",
               c, busy4, wda4, wta4, idx4, men4, addr4);
      chk("w4.busy", c, 32'(busy4), 32'(c >= 1 && c <= 6));
      chk("w4.men",  c, 32'(men4),  32'(c >= 1 && c <= 4));
      chk("w4.addr", c, 32'(addr4), (c >= 1 && c <= 4) ? 32'h0F30 + 32'(4 * (c - 1)) : 32'h0);
      chk("w4.wda",  c, 32'(wda4),  32'(c >= 2 && c <= 5));
      chk("w4.idx",  c, 32'(idx4),  (c >= 2 && c <= 5) ? 32'(c - 2) : 32'h0);
      chk("w4.wta",  c, 32'(wta4),  32'(c == 6));
      chk("w4.wr",   c, 32'(mwr4),  32'h0);
      chk("w4.wdata", c, wdata4,    32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Parametrised cache-line fill controller, successor to the single-word-per-response fill FSM. On a miss it optionally writes back a dirty victim line, then streams a full line of read requests into a pipelined memory without waiting for each response. It writes returning words into the cache data array in order and writes the tag once the line is complete. It sits between the I/D-cache tag-match logic and the shared memory port, and `fsm_busy` stalls the pipeline.

## Interface
- `ADDR_W`, default 16: byte address width.
- `DATA_W`, default 16: memory word width.
- `WORDS`, default 8: words per cache line; power of two, ≥2. `IDX_W = log2(WORDS)`.
- `BYTE_OFF`, default 1: log2 of bytes per word. `OFF_W = IDX_W + BYTE_OFF`.

Ports (reset is synchronous, active-low, on `rst_n` sampled at posedge `clk`):
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `miss_detected` in 1: tag-match miss, sampled only in IDLE.
- `miss_address` in ADDR_W: address that missed.
- `victim_dirty` in 1: the line being replaced is dirty, sampled with `miss_detected`.
- `victim_address` in ADDR_W: any address within the victim line.
- `victim_data` in DATA_W: combinational data-array read at `word_index`.
- `memory_data_valid` in 1: read data valid on the memory bus. Responses arrive in order.
- `fsm_busy` out 1: controller is handling a miss.
- `write_data_array` out 1: write enable for the data array.
- `write_tag_array` out 1: write enable for the tag and valid bit.
- `word_index` out IDX_W: data-array word select.
- `memory_enable` out 1: memory request this cycle.
- `memory_wr` out 1: 1 means write, 0 means read. Meaningful only with `memory_enable`.
- `memory_address` out ADDR_W: request address.
- `memory_wdata` out DATA_W: write data.

## Operation
- The controller has four states: IDLE, WB, FILL and TAG.
- On the IDLE→WB or IDLE→FILL transition, it latches the line bases `miss_base = miss_address[ADDR_W-1:OFF_W]` and `victim_base` the same way. Inputs need not be held after that.
- **IDLE**
  - `miss_detected & victim_dirty` goes to WB.
  - `miss_detected & ~victim_dirty` goes to FILL.
  - Otherwise it stays in IDLE.
- **WB**
  - One write per cycle, for `wb_cnt` = 0..WORDS-1.
  - Outputs: `memory_enable=1`, `memory_wr=1`, `memory_address={victim_base, wb_cnt, BYTE_OFF'b0}`, `word_index=wb_cnt`, `memory_wdata=victim_data`.
  - After the write with `wb_cnt=WORDS-1`, the next state is FILL.
- **FILL**
  - The issue counter `iss_cnt` (IDX_W+1 bits) issues one read per cycle while `iss_cnt<WORDS`: `memory_enable=1`, `memory_wr=0`, `memory_address={miss_base, iss_cnt[IDX_W-1:0], BYTE_OFF'b0}`.
  - The receive counter `rx_cnt` (IDX_W+1 bits) increments on each `memory_data_valid`.
  - Data-array writes: `write_data_array = memory_data_valid`, `word_index = rx_cnt[IDX_W-1:0]`.
  - When a valid response arrives with `rx_cnt==WORDS-1`, the next state is TAG.
  - Issue and receive proceed concurrently.
- **TAG**
  - Held for one cycle with `write_tag_array=1`, then the controller returns to IDLE.
- **Busy and idle outputs**
  - `fsm_busy=1` in WB, FILL and TAG.
  - When not issuing a request: `memory_enable=0`, `memory_wr=0`, `memory_address=0`, `memory_wdata=0`.
- **Ignored inputs and counter behaviour**
  - `memory_data_valid` outside FILL is ignored.
  - `miss_detected` outside IDLE is ignored.
  - Counters never wrap mid-line. All counters clear on entry to WB or FILL.

## Timing
- Reset: state is IDLE and all counters are 0. Every output is 0 in the cycle after `rst_n` is sampled low, including when reset arrives mid-WB or mid-FILL.
- Memory latency L (≥1) is the number of cycles from the request cycle to the `memory_data_valid` cycle. Valid may have gaps.
- Clean miss sampled in cycle 0:
  - Reads are issued in cycles 1..WORDS.
  - With no gaps, data is written in cycles 1+L..WORDS+L.
  - TAG is in cycle WORDS+L+1.
  - `fsm_busy` is high in cycles 1..WORDS+L+1. IDLE is reached in cycle WORDS+L+2.
- Dirty miss: WB takes cycles 1..WORDS and everything above shifts by WORDS cycles.
- A new `miss_detected` is accepted in the first IDLE cycle after TAG.
- If `memory_data_valid` arrives in the same cycle as a FILL read issue, both actions take effect.

## Test plan
- **Clean miss, `miss_address=0x1234`, WORDS=8, L=4, no gaps.** Read addresses 0x1230, 0x1232, …, 0x123E in cycles 1–8. `write_data_array` in cycles 5–12 with `word_index` 0..7. `write_tag_array` in cycle 13 only. `fsm_busy` high in cycles 1–13.
- **Dirty miss, `victim_address=0xABC6`, `miss_address=0x1234`.** Writes to 0xABC0..0xABCE with `memory_wr=1` and `memory_wdata=victim_data` in cycles 1–8. Reads to 0x1230.. in cycles 9–16. Tag written in cycle 21.
- **Gapped responses: `memory_data_valid` deasserted every other response cycle.** `word_index` advances only on valid. Exactly 8 data writes occur. The tag is written the cycle after the 8th valid.
- **`miss_detected` pulsed during FILL, and a spurious `memory_data_valid` in IDLE.** No state change and no array writes result.
- **`rst_n` low in cycle 6 of a fill.** All outputs are 0 from cycle 7. A new miss in cycle 8 restarts at word 0.
- **Parameter variant WORDS=4, DATA_W=32, BYTE_OFF=2, `miss_address=0x0F3C`.** Reads at 0x0F30, 0x0F34, 0x0F38, 0x0F3C. 4 data writes, then 1 tag write.
